// File: rtl/elevator_request_scheduler.sv
// Request latch and SCAN motion sequencer for a small elevator car.
// Define ESTOP_EN to add an `estop` input that freezes motion and timing.
module elevator_request_scheduler #(
  parameter int NF         = 3,
  parameter int TRAVEL_CYC = 100_000_000,
  parameter int DOOR_CYC   = 50_000_000,
  parameter int TW         = 27
) (
  input  logic          clk,
  input  logic          reset,
`ifdef ESTOP_EN
  input  logic          estop,
`endif
  input  logic [NF-1:0] req,
  output logic [NF-1:0] pending,
  output logic [2:0]    cur_floor,
  output logic          dir_up,
  output logic          dir_dn,
  output logic          door_open,
  output logic          busy
);

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYC - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    floor_nx, new_floor;
  logic [NF-1:0] pend_nx, pend_merged, req_q, press, here, arrive_mask;
  logic          last_up, last_up_nx;
  logic          at_rest, here_press, go_up, frozen;

  function automatic logic [NF-1:0] floor_mask(input logic [2:0] f);
    logic [NF-1:0] m;
    m = '0;
    for (int i = 0; i < NF; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  // Floors strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic [NF-1:0] side_mask(input logic [2:0] f, input logic up);
    logic [NF-1:0] m;
    m = '0;
    for (int i = 0; i < NF; i++) m[i] = up ? (i > int'(f)) : (i < int'(f));
    return m;
  endfunction

`ifdef ESTOP_EN
  assign frozen = estop;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    press       = req & ~req_q;
    at_rest     = (state == IDLE) || (state == DOOR);
    here        = floor_mask(cur_floor);
    here_press  = at_rest && ((press & here) != '0);
    pend_merged = pending | (at_rest ? (press & ~here) : press);
    new_floor   = (state == MOVE_DN) ? cur_floor - 3'd1 : cur_floor + 3'd1;
    arrive_mask = floor_mask(new_floor);
    go_up       = last_up ? ((pending & side_mask(cur_floor, 1'b1)) != '0)
                          : ((pending & side_mask(cur_floor, 1'b0)) == '0);

    state_nx   = state;
    timer_nx   = timer;
    floor_nx   = cur_floor;
    pend_nx    = pend_merged;
    last_up_nx = last_up;

    case (state)
      IDLE: begin
        if (here_press) begin
          state_nx = DOOR;
          timer_nx = '0;
        end else if (pending != '0) begin
          state_nx   = go_up ? MOVE_UP : MOVE_DN;
          last_up_nx = go_up;
          timer_nx   = '0;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (timer == TRAVEL_LAST) begin
          floor_nx = new_floor;
          timer_nx = '0;
          // Presses landing on the arrival edge still count for this stop.
          if ((pend_merged & arrive_mask) != '0) begin
            pend_nx  = pend_merged & ~arrive_mask;
            state_nx = DOOR;
          end else if ((pend_merged & side_mask(new_floor, state == MOVE_UP)) == '0) begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      DOOR: begin
        if (here_press) begin
          timer_nx = '0;
        end else if (timer == DOOR_LAST) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (frozen) begin
      state_nx   = state;
      timer_nx   = timer;
      floor_nx   = cur_floor;
      pend_nx    = pending;
      last_up_nx = last_up;
    end
  end

  // req_q tracks req even while frozen so buttons held through a stop never fire later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      cur_floor <= '0;
      pending   <= '0;
      req_q     <= '0;
      last_up   <= 1'b1;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      cur_floor <= floor_nx;
      pending   <= pend_nx;
      req_q     <= req;
      last_up   <= last_up_nx;
    end
  end

  assign dir_up    = (state == MOVE_UP) && !frozen;
  assign dir_dn    = (state == MOVE_DN) && !frozen;
  assign door_open = (state == DOOR);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: a behavioural car model queues expected
// outputs each cycle, a monitor consumes them; directed scenario checks share the same monitor.
module tb_elevator_request_scheduler;
  localparam int NF = 3;
  localparam int TC = 10;
  localparam int DC = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] req;
  logic [NF-1:0] pending;
  logic [2:0]    cur_floor;
  logic          dir_up, dir_dn, door_open, busy;
`ifdef ESTOP_EN
  logic          estop;
`endif

  elevator_request_scheduler #(.NF(NF), .TRAVEL_CYC(TC), .DOOR_CYC(DC), .TW(8)) dut (
    .clk(clk),
    .reset(reset),
`ifdef ESTOP_EN
    .estop(estop),
`endif
    .req(req),
    .pending(pending),
    .cur_floor(cur_floor),
    .dir_up(dir_up),
    .dir_dn(dir_dn),
    .door_open(door_open),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    actual;
    int    expected;
  } chk_t;

  logic [9:0] exp_q[$];
  chk_t       chk_q[$];
  int         exp_rd = 0;
  int         chk_rd = 0;
  int         tests = 0;
  int         fails = 0;

  // Behavioural car: floor as an integer, heading +1/-1, countdown of remaining cycles.
  int            m_floor, m_heading, m_last, m_remaining;
  bit            m_moving, m_door;
  logic [NF-1:0] m_pend, m_prev;

  function automatic bit any_beyond(input logic [NF-1:0] p, input int from, input int dir);
    for (int i = 0; i < NF; i++)
      if (p[i] && ((dir > 0 && i > from) || (dir < 0 && i < from))) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    logic [NF-1:0] old;
    bit hit, stopped;
`ifdef ESTOP_EN
    stopped = estop;
`else
    stopped = 1'b0;
`endif
    if (reset) begin
      m_floor = 0; m_heading = 1; m_last = 1; m_remaining = 0;
      m_moving = 0; m_door = 0; m_pend = '0; m_prev = '0;
    end else begin
      old = m_pend;
      hit = 0;
      for (int i = 0; i < NF; i++) begin
        if (!stopped && req[i] && !m_prev[i]) begin
          if (i == m_floor && !m_moving) hit = 1;
          else m_pend[i] = 1'b1;
        end
      end
      m_prev = req;
      if (stopped) begin
        // frozen: nothing advances
      end else if (m_moving) begin
        m_remaining--;
        if (m_remaining == 0) begin
          m_floor += m_heading;
          if (m_pend[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            m_moving = 0; m_door = 1; m_remaining = DC;
          end else if (any_beyond(m_pend, m_floor, m_heading)) begin
            m_remaining = TC;
          end else begin
            m_moving = 0;
          end
        end
      end else if (m_door) begin
        if (hit) m_remaining = DC;
        else begin
          m_remaining--;
          if (m_remaining == 0) m_door = 0;
        end
      end else if (hit) begin
        m_door = 1; m_remaining = DC;
      end else if (old != '0) begin
        m_heading = any_beyond(old, m_floor, m_last) ? m_last : -m_last;
        m_last = m_heading; m_moving = 1; m_remaining = TC;
      end
    end
    exp_q.push_back({m_pend, 3'(m_floor), m_moving && m_heading > 0 && !stopped,
                     m_moving && m_heading < 0 && !stopped, m_door, m_moving || m_door});
  end

  // Monitor: one expected snapshot per clock, plus any queued directed checks.
  always begin
    logic [9:0] got;
    @(posedge clk);
    #1;
    if (exp_rd < exp_q.size()) begin
      got = {pending, cur_floor, dir_up, dir_dn, door_open, busy};
      tests++;
      if (got !== exp_q[exp_rd]) begin
        fails++;
        $display("[TB] FAIL scoreboard @%0t: dut {pend,floor,up,dn,door,busy}=%b expected=%b",
                 $time, got, exp_q[exp_rd]);
      end
      exp_rd++;
    end
    while (chk_rd < chk_q.size()) begin
      tests++;
      if (chk_q[chk_rd].actual != chk_q[chk_rd].expected) begin
        fails++;
        $display("[TB] FAIL %s: got %0d expected %0d", chk_q[chk_rd].name,
                 chk_q[chk_rd].actual, chk_q[chk_rd].expected);
      end
      chk_rd++;
    end
  end

  int            cnt_up, cnt_dn, cnt_door, cnt_busy;
  logic [NF-1:0] s_pending;
  logic [2:0]    s_floor;
  logic          s_door, s_busy;
  logic [9:0]    s_all;

  task automatic clearCounts();
    cnt_up = 0; cnt_dn = 0; cnt_door = 0; cnt_busy = 0;
  endtask

  task automatic applyStimulus(input logic [NF-1:0] r, input logic rst);
    @(negedge clk);
    s_pending = pending; s_floor = cur_floor; s_door = door_open; s_busy = busy;
    s_all = {pending, cur_floor, dir_up, dir_dn, door_open, busy};
    if (dir_up) cnt_up++;
    if (dir_dn) cnt_dn++;
    if (door_open) cnt_door++;
    if (busy) cnt_busy++;
    req = r;
    reset = rst;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    chk_q.push_back('{name, actual, expected});
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b0);
  endtask

  initial begin
    logic [NF-1:0] r;
    req = '0;
    reset = 1'b1;
`ifdef ESTOP_EN
    estop = 1'b0;
`endif
    repeat (3) applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("reset_state", int'(s_all), 0);

    // single call to floor 1
    clearCounts();
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b000, 1'b0);
    checkOutput("s1_pending_latched", int'(s_pending), 3'b010);
    clearCounts();
    repeat (20) applyStimulus(3'b000, 1'b0);
    checkOutput("s1_up_cycles", cnt_up, TC);
    checkOutput("s1_door_cycles", cnt_door, DC);
    checkOutput("s1_floor", int'(s_floor), 1);
    checkOutput("s1_pending_clear", int'(s_pending), 0);
    checkOutput("s1_busy_end", int'(s_busy), 0);

    // floors 1 and 2 in one press from ground
    doReset();
    clearCounts();
    applyStimulus(3'b110, 1'b0);
    repeat (60) applyStimulus(3'b000, 1'b0);
    checkOutput("s2_up_cycles", cnt_up, 2 * TC);
    checkOutput("s2_dn_cycles", cnt_dn, 0);
    checkOutput("s2_door_cycles", cnt_door, 2 * DC);
    checkOutput("s2_floor", int'(s_floor), 2);

    // same-floor press then dwell re-press three cycles in
    clearCounts();
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b000, 1'b0);
    checkOutput("s3_same_floor_door", int'(s_door), 1);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b100, 1'b0);
    repeat (20) applyStimulus(3'b000, 1'b0);
    checkOutput("s3_door_cycles", cnt_door, DC + 3);
    checkOutput("s3_no_motion", cnt_up + cnt_dn, 0);

    // call to ground placed while travelling 1->2
    doReset();
    clearCounts();
    for (int k = 0; k < 70; k++)
      applyStimulus(k == 0 ? 3'b100 : (k == 15 ? 3'b001 : 3'b000), 1'b0);
    checkOutput("s4_up_cycles", cnt_up, 2 * TC);
    checkOutput("s4_dn_cycles", cnt_dn, 2 * TC);
    checkOutput("s4_door_cycles", cnt_door, 2 * DC);
    checkOutput("s4_floor", int'(s_floor), 0);

    // reset in the middle of a move
    doReset();
    applyStimulus(3'b100, 1'b0);
    repeat (14) applyStimulus(3'b000, 1'b0);
    checkOutput("s5_floor_before_reset", int'(s_floor), 1);
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b000, 1'b0);
    checkOutput("s5_all_zero", int'(s_all), 0);
    clearCounts();
    repeat (30) applyStimulus(3'b000, 1'b0);
    checkOutput("s5_no_stale_busy", cnt_busy, 0);

`ifdef ESTOP_EN
    doReset();
    clearCounts();
    for (int k = 0; k < 40; k++) begin
      applyStimulus(k == 0 ? 3'b010 : 3'b000, 1'b0);
      estop = (k >= 5 && k < 12);
    end
    checkOutput("estop_up_cycles", cnt_up, TC);
    checkOutput("estop_door_cycles", cnt_door, DC);
    checkOutput("estop_floor", int'(s_floor), 1);
`endif

    // randomized traffic against the model
    r = '0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 3) != 0)
        r = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(0, (1 << NF) - 1)) : '0;
      applyStimulus(r, $urandom_range(0, 399) == 0);
`ifdef ESTOP_EN
      if ($urandom_range(0, 49) == 0) estop = ~estop;
`endif
    end
`ifdef ESTOP_EN
    estop = 1'b0;
`endif
    repeat (4) applyStimulus('0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Request scheduler and motion sequencer for the three-floor elevator controller. It latches floor-button presses, picks a travel direction using a collective (SCAN) policy, and times each floor-to-floor move and door-open dwell. Its outputs drive the floor LEDs and the seven-segment display logic in the controller top.

## Interface
Parameters:
- `NF`, 3: number of floors, legal range 2..8. Floor index 0 is the ground floor.
- `TRAVEL_CYC`, 100_000_000: clock cycles per one-floor move. 1 s at 100 MHz.
- `DOOR_CYC`, 50_000_000: clock cycles of door-open dwell.
- `TW`, 27: timer width. Must satisfy 2^TW > max(TRAVEL_CYC, DOOR_CYC).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high reset.
- `req` in NF: floor buttons, level, already synchronous to `clk`. Bit i = floor i.
- `pending` out NF: latched outstanding requests.
- `cur_floor` out 3: current floor index.
- `dir_up` out 1: car moving up.
- `dir_dn` out 1: car moving down.
- `door_open` out 1: door open at `cur_floor`.
- `busy` out 1: state is not IDLE.

## Operation
- Edge detection:
  - A register `req_q` holds the previous value of `req`; reset value 0.
  - A press is `req & ~req_q`.
  - Held buttons never re-trigger.
- Press at floor i:
  - If i == `cur_floor` and state is IDLE or DOOR: open the door or restart the dwell. `pending[i]` is not set.
  - Otherwise, including during MOVE: set `pending[i]`.
- States are IDLE, MOVE_UP, MOVE_DN and DOOR. Register `last_dir` reset value is up.
- IDLE:
  - `pending` == 0: stay in IDLE.
  - If a request exists in the `last_dir` direction relative to `cur_floor`, go to the MOVE state for that direction.
  - Otherwise go to the opposite MOVE state.
  - Entering a MOVE state sets `last_dir` and loads the timer with 0.
- MOVE_UP / MOVE_DN:
  - The timer counts up.
  - At count TRAVEL_CYC-1, `cur_floor` changes by ±1 and the timer clears.
  - If `pending[new floor]` is set: clear that bit and go to DOOR.
  - Otherwise, if a request exists beyond the new floor in the same direction: keep moving.
  - Otherwise go to IDLE.
- DOOR:
  - The timer counts DOOR_CYC cycles, then the state goes to IDLE.
  - A press at `cur_floor` restarts the timer at 0.
- Boundaries:
  - `cur_floor` never leaves 0..NF-1. No move is issued beyond the end floors.
  - Presses on several floors in the same cycle are all latched.
  - A request for the floor just departed is served on the return trip.
- Reset mid-operation returns everything to reset values on the next edge. A car between floors is treated as floor 0.

## Timing
- Reset values: `pending`=0, `cur_floor`=0, `dir_up`=0, `dir_dn`=0, `door_open`=0, `busy`=0, timer=0, state IDLE.
- All outputs are registered and decode from the state and registers.
- Press at edge t: `pending` is visible at t+1. The IDLE→MOVE transition happens at t+2, with `dir_up`/`dir_dn` high from t+2.
- `cur_floor` updates exactly TRAVEL_CYC cycles after MOVE is entered, on the same edge as MOVE→DOOR.
- `door_open` is high for exactly DOOR_CYC cycles, or longer if the dwell is re-pressed. IDLE follows, and the next decision is taken one cycle later.
- A same-floor press in IDLE makes `door_open` high on the next edge.

## Configuration
- `ESTOP_EN` defined:
  - Adds input port `estop` (1 bit).
  - While `estop` is high: state and timer freeze, `dir_up`/`dir_dn` are forced to 0, presses are ignored, and `door_open` and `pending` hold their values.
  - Release resumes from the frozen timer value.
- `ESTOP_EN` undefined: no `estop` port; behaviour is identical to `estop`=0.

## Test plan
Bench parameters: NF=3, TRAVEL_CYC=10, DOOR_CYC=5.
- Reset, then pulse `req`=010 for 1 cycle:
  - `pending`=010 next cycle.
  - `dir_up` high 10 cycles.
  - `cur_floor`=1, `pending`=000.
  - `door_open` high 5 cycles, then `busy`=0.
- At floor 0, `req`=110 in one cycle: stop at 1 with 5-cycle door, then continue to 2 with 5-cycle door. `dir_dn` is never asserted.
- At floor 2, door open, re-press `req`[2] 3 cycles into the dwell: `door_open` stays high 5 cycles after the re-press (8 total).
- Moving 1→2 with `pending`=100, press `req`[0]: car reaches 2 with door, then moves down to 0 (20 cycles of `dir_dn`).
- Assert `reset` mid-MOVE_UP: next edge all outputs 0 and `cur_floor`=0. No stale `pending` resumes.
- With `ESTOP_EN`, raise `estop` 4 cycles into a move for 7 cycles: `dir_up`=0 and timer held. After release, arrival occurs 6 cycles later.
